// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - GPIO bank: synchronised inputs, output/direction registers, bus register file
// Edge detection, interrupt status and irq are built only when GPIO_BANK_IRQ_EN is defined.
module gpio_bank #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bSel,
   input  logic             bWrite,
   input  logic [31:0]      bAddr,
   input  logic [31:0]      bWData,
   output logic [31:0]      bRData,
   input  logic [WIDTH-1:0] gpioInput,
   output logic [WIDTH-1:0] gpioOutput,
   output logic [WIDTH-1:0] gpioOe,
   output logic             irq
);

   localparam logic [2:0] REG_IN      = 3'd0;
   localparam logic [2:0] REG_OUT     = 3'd1;
   localparam logic [2:0] REG_DIR     = 3'd2;
   localparam logic [2:0] REG_OUT_SET = 3'd3;
   localparam logic [2:0] REG_OUT_CLR = 3'd4;
   localparam logic [2:0] REG_IRQ_EN  = 3'd5;
   localparam logic [2:0] REG_EDGE    = 3'd6;
   localparam logic [2:0] REG_STAT    = 3'd7;

   logic [WIDTH-1:0] syncQ [SYNC_STAGES];
   logic [WIDTH-1:0] inSync;
   logic [WIDTH-1:0] outReg;
   logic [WIDTH-1:0] dirReg;
   logic [WIDTH-1:0] wData;
   logic [WIDTH-1:0] irqEn;
   logic [WIDTH-1:0] edgeSel;
   logic [WIDTH-1:0] irqStat;
   logic [WIDTH-1:0] rdVal;
   logic [2:0]       regIdx;
   logic             wrEn;
   logic             unusedBits;

   assign regIdx     = bAddr[4:2];
   assign wrEn       = bSel & bWrite;
   assign wData      = bWData[WIDTH-1:0];
   assign inSync     = syncQ[SYNC_STAGES-1];
   assign gpioOutput = outReg;
   assign gpioOe     = dirReg;
   assign unusedBits = ^{bAddr[31:5], bAddr[1:0], bWData};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) syncQ[i] <= '0;
      end else begin
         syncQ[0] <= gpioInput;
         for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outReg <= '0;
         dirReg <= '0;
      end else if (wrEn) begin
         case (regIdx)
            REG_OUT:     outReg <= wData;
            REG_DIR:     dirReg <= wData;
            REG_OUT_SET: outReg <= outReg | wData;
            REG_OUT_CLR: outReg <= outReg & ~wData;
            default:     ;
         endcase
      end
   end

`ifdef GPIO_BANK_IRQ_EN
   logic [WIDTH-1:0] inDly;
   logic [WIDTH-1:0] edgeHit;
   logic [WIDTH-1:0] w1cMask;
   logic             irqQ;

   assign edgeHit = (inSync & ~inDly & edgeSel) | (~inSync & inDly & ~edgeSel);
   assign w1cMask = (wrEn && regIdx == REG_STAT) ? wData : '0;
   assign irq     = irqQ;

   // New edges are OR-ed in after the clear so a coincident edge keeps its bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inDly   <= '0;
         irqEn   <= '0;
         edgeSel <= '0;
         irqStat <= '0;
         irqQ    <= 1'b0;
      end else begin
         inDly   <= inSync;
         irqStat <= (irqStat & ~w1cMask) | edgeHit;
         irqQ    <= |(irqStat & irqEn);
         if (wrEn && regIdx == REG_IRQ_EN) irqEn   <= wData;
         if (wrEn && regIdx == REG_EDGE)   edgeSel <= wData;
      end
   end
`else
   assign irqEn   = '0;
   assign edgeSel = '0;
   assign irqStat = '0;
   assign irq     = 1'b0;
`endif

   always_comb begin
      rdVal = '0;
      if (bSel) begin
         case (regIdx)
            REG_IN:     rdVal = inSync;
            REG_OUT:    rdVal = outReg;
            REG_DIR:    rdVal = dirReg;
            REG_IRQ_EN: rdVal = irqEn;
            REG_EDGE:   rdVal = edgeSel;
            REG_STAT:   rdVal = irqStat;
            default:    rdVal = '0;
         endcase
      end
      bRData = '0;
      bRData[WIDTH-1:0] = rdVal;
   end

endmodule
